regfile_cmd_ctrl: RTL and testbench
===================================

REGFILE_CMD_CTRL -- requirements
Module: regfile_cmd_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, register data width.
REQ-002 Parameter: ADDR, 3, register address width (2^ADDR = 8 entries).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset. Port names SHALL follow the codebase convention (CLK, RST).
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  controller accepts a command this cycle.
REQ-008 cmd_op  input  1  0 = write, 1 = read burst.
REQ-009 cmd_addr  input  ADDR  start address.
REQ-010 cmd_len  input  3  read burst length minus 1 (0..7); ignored for writes.
REQ-011 cmd_data  input  WIDTH  write data.
REQ-012 rsp_valid  output  1  read word available.
REQ-013 rsp_ready  input  1  consumer accepts the word.
REQ-014 rsp_data  output  WIDTH  read word.
REQ-015 rsp_addr  output  ADDR  address the word was read from.
REQ-016 rsp_last  output  1  final word of the burst.
REQ-017 Address  output  ADDR  register-file address.
REQ-018 WrEn  output  1  register-file write enable.
REQ-019 RdEn  output  1  register-file read enable.
REQ-020 WrData  output  WIDTH  register-file write data.
REQ-021 RdData  input  WIDTH  register-file read data; valid the cycle after RdEn is sampled.

Function
REQ-022 The FSM SHALL have five states (IDLE, WR, RD, CAP, RSP), held in a register. All outputs SHALL be driven from registers or decoded from state.
REQ-023 cmd_ready SHALL be 1 only in IDLE. A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1. Accepting a command SHALL latch cmd_op, cmd_addr, cmd_len and cmd_data.
REQ-024 IDLE -> WR on an accepted write. WR SHALL last exactly one cycle with WrEn=1, Address=latched address and WrData=latched data, then return to IDLE.
REQ-025 IDLE -> RD on an accepted read. RD SHALL last one cycle with RdEn=1 and Address=current address.
REQ-026 RD -> CAP. In CAP, RdData SHALL be captured into rsp_data and Address into rsp_addr at the end of the cycle.
REQ-027 CAP -> RSP. rsp_valid SHALL be 1 throughout RSP. rsp_data, rsp_addr and rsp_last SHALL stay stable until rsp_valid and rsp_ready are both 1 on a rising edge.
REQ-028 On the RSP handshake:
- if the beat counter equals cmd_len, the FSM SHALL go to IDLE;
- otherwise the address SHALL increment modulo 2^ADDR (7 -> 0 wrap), the beat counter SHALL increment, and the FSM SHALL go to RD.
REQ-029 rsp_last SHALL be 1 when the beat counter equals latched cmd_len.
REQ-030 Timing:
- write: accept edge to WrEn high = 1 cycle; next command accepted 2 cycles after the previous one;
- read: accept edge to first rsp_valid = 3 cycles.
REQ-031 WrEn and RdEn SHALL never both be 1. Both SHALL be 0 outside WR and RD.
REQ-032 cmd_valid while not in IDLE SHALL be ignored. The command stays pending upstream.
REQ-033 rsp_ready=1 outside RSP SHALL have no effect.
REQ-034 rsp_ready held at 0 SHALL stall the FSM in RSP indefinitely, with no further RdEn.

Reset
REQ-035 RST=1 SHALL immediately, without waiting for CLK, force:
- state=IDLE;
- cmd_ready=1 once RST=0;
- rsp_valid=0, rsp_last=0, WrEn=0, RdEn=0;
- Address=0, WrData=0, rsp_data=0, rsp_addr=0;
- beat counter=0.
REQ-036 RST asserted mid-burst or mid-write SHALL abort the operation. Any pending response SHALL be discarded and no further register-file access SHALL occur.
REQ-037 The first command SHALL be accepted on the first rising edge after RST deasserts.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
- Writes 7<-0x0001, 1<-0x001C, 5<-0x000A, then single reads of 7, 1, 5 -> rsp_data = 0x0001, 0x001C, 0x000A; rsp_last=1 on each.
- Read burst addr=6, len=3 after writing 6=0x0A06, 7=0x0A07, 0=0x0A00, 1=0x0A01 -> rsp_addr 6,7,0,1 (wrap), matching data, rsp_last only on the 4th word.
- Burst len=1 with rsp_ready low for 5 cycles on the first beat -> rsp_valid/rsp_data stable for 5 cycles, RdEn stays 0, second beat follows afterwards.
- Back-to-back writes with cmd_valid held at 1 -> WrEn pulses exactly every 2 cycles, cmd_ready=0 in WR, WrEn&RdEn never 1.
- RST asserted mid-edge during the 2nd beat of a len=7 burst -> rsp_valid=0, RdEn=0, cmd_ready=1 immediately after release; a following read of 7 returns the previously written value.
- Timing check on a single read -> RdEn one cycle after accept, rsp_valid exactly 3 cycles after the accept edge.

Source files
------------

// File: rtl/regfile_cmd_ctrl.sv
// Command front-end for an 8-entry register file: single-cycle writes and
// read bursts returned one word at a time over a valid/ready response port.
module regfile_cmd_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ADDR  = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_op,
   input  logic [ADDR-1:0]  cmd_addr,
   input  logic [2:0]       cmd_len,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [ADDR-1:0]  rsp_addr,
   output logic             rsp_last,
   output logic [ADDR-1:0]  Address,
   output logic             WrEn,
   output logic             RdEn,
   output logic [WIDTH-1:0] WrData,
   input  logic [WIDTH-1:0] RdData
);

   typedef enum logic [2:0] {StIdle, StWr, StRd, StCap, StRsp} state_e;

   state_e           state_q, state_d;
   logic [ADDR-1:0]  addr_q;
   logic [WIDTH-1:0] data_q;
   logic [2:0]       len_q;
   logic [2:0]       beat_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [ADDR-1:0]  rsp_addr_q;

   logic accept;
   logic rsp_fire;
   logic beat_end;

   assign accept   = cmd_valid && (state_q == StIdle);
   assign rsp_fire = rsp_ready && (state_q == StRsp);
   assign beat_end = (beat_q == len_q);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = cmd_op ? StRd : StWr;
            end
         end
         StWr:  state_d = StIdle;
         StRd:  state_d = StCap;
         StCap: state_d = StRsp;
         StRsp: begin
            if (rsp_fire) begin
               state_d = beat_end ? StIdle : StRd;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == StIdle);
      WrEn      = (state_q == StWr);
      RdEn      = (state_q == StRd);
      rsp_valid = (state_q == StRsp);
      rsp_last  = (state_q == StRsp) && beat_end;
   end

   // Command latch and burst address/beat bookkeeping.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q <= '0;
         data_q <= '0;
         len_q  <= '0;
         beat_q <= '0;
      end else if (accept) begin
         addr_q <= cmd_addr;
         data_q <= cmd_data;
         len_q  <= cmd_len;
         beat_q <= '0;
      end else if (rsp_fire && !beat_end) begin
         addr_q <= addr_q + {{(ADDR-1){1'b0}}, 1'b1};
         beat_q <= beat_q + 3'd1;
      end
   end

   // RdData is valid in the cycle after RdEn, i.e. while in StCap.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rsp_data_q <= '0;
         rsp_addr_q <= '0;
      end else if (state_q == StCap) begin
         rsp_data_q <= RdData;
         rsp_addr_q <= addr_q;
      end
   end

   assign Address  = addr_q;
   assign WrData   = data_q;
   assign rsp_data = rsp_data_q;
   assign rsp_addr = rsp_addr_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed self-checking bench for regfile_cmd_ctrl with a behavioural
// 8x16 register file attached to the Address/WrEn/RdEn/WrData/RdData port.
module tb_regfile_cmd_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [2:0]  cmd_addr;
   logic [2:0]  cmd_len;
   logic [15:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_addr;
   logic        rsp_last;
   logic [2:0]  Address;
   logic        WrEn;
   logic        RdEn;
   logic [15:0] WrData;
   logic [15:0] RdData;

   logic [15:0] mem [8];

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   regfile_cmd_ctrl #(.WIDTH(16), .ADDR(3)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_last(rsp_last),
      .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .RdData(RdData)
   );

   always @(posedge CLK) begin
      if (WrEn) mem[Address] <= WrData;
      if (RdEn) RdData <= mem[Address];
   end

   // Offer one command from IDLE and return once it has been accepted.
   task automatic send_cmd(input logic op, input logic [2:0] addr, input logic [2:0] len,
                           input logic [15:0] data, output logic ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge CLK);
         if (cmd_ready === 1'b1) ok = 1'b1;
         n++;
      end
      if (ok) begin
         cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
         @(posedge CLK);
         #1 cmd_valid = 1'b0;
      end
   endtask

   // Wait for a response word, sample it, then handshake it.
   task automatic get_beat(output logic ok, output logic [15:0] d, output logic [2:0] a,
                           output logic l);
      int n = 0;
      ok = 1'b0; d = 'x; a = 'x; l = 1'bx;
      while (!ok && n < 50) begin
         @(negedge CLK);
         if (rsp_valid === 1'b1) ok = 1'b1;
         n++;
      end
      if (ok) begin
         d = rsp_data; a = rsp_addr; l = rsp_last;
         rsp_ready = 1'b1;
         @(posedge CLK);
         #1 rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_len = 0; cmd_data = 0; rsp_ready = 0;
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      vectors++;
      if ({rsp_valid, rsp_last, WrEn, RdEn} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b want 0000", {rsp_valid, rsp_last, WrEn, RdEn});
      end
      vectors++;
      if ({Address, WrData, rsp_data, rsp_addr} !== 38'd0) begin
         miscompares++;
         $display("FAIL reset_data: addr=%h wrdata=%h rsp_data=%h rsp_addr=%h want 0",
                  Address, WrData, rsp_data, rsp_addr);
      end
      RST = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
      end
   endtask

   task automatic test_write_read();
      logic [2:0]  wa [3] = '{3'd7, 3'd1, 3'd5};
      logic [15:0] wd [3] = '{16'h0001, 16'h001C, 16'h000A};
      logic ok, l;
      logic [15:0] d;
      logic [2:0] a;
      for (int i = 0; i < 3; i++) begin
         send_cmd(1'b0, wa[i], 3'd0, wd[i], ok);
         vectors++;
         if (ok !== 1'b1) begin
            miscompares++; $display("FAIL wr_accept[%0d]: accepted=%b want 1", i, ok);
         end
      end
      for (int i = 0; i < 3; i++) begin
         send_cmd(1'b1, wa[i], 3'd0, 16'h0, ok);
         get_beat(ok, d, a, l);
         vectors++;
         if ({ok, d, a, l} !== {1'b1, wd[i], wa[i], 1'b1}) begin
            miscompares++;
            $display("FAIL single_read[%0d]: ok=%b data=%h addr=%0d last=%b want 1 %h %0d 1",
                     i, ok, d, a, l, wd[i], wa[i]);
         end
      end
   endtask

   task automatic test_burst_wrap();
      logic [2:0]  ba [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
      logic [15:0] bd [4] = '{16'h0A06, 16'h0A07, 16'h0A00, 16'h0A01};
      logic ok, l;
      logic [15:0] d;
      logic [2:0] a;
      for (int i = 0; i < 4; i++) send_cmd(1'b0, ba[i], 3'd0, bd[i], ok);
      send_cmd(1'b1, 3'd6, 3'd3, 16'h0, ok);
      for (int i = 0; i < 4; i++) begin
         get_beat(ok, d, a, l);
         vectors++;
         if ({ok, d, a, l} !== {1'b1, bd[i], ba[i], (i == 3)}) begin
            miscompares++;
            $display("FAIL burst_wrap[%0d]: ok=%b data=%h addr=%0d last=%b want 1 %h %0d %b",
                     i, ok, d, a, l, bd[i], ba[i], (i == 3));
         end
      end
   endtask

   task automatic test_stall();
      logic ok, l;
      logic [15:0] d;
      logic [2:0] a;
      int n = 0;
      send_cmd(1'b0, 3'd2, 3'd0, 16'h1234, ok);
      send_cmd(1'b0, 3'd3, 3'd0, 16'h5678, ok);
      send_cmd(1'b1, 3'd2, 3'd1, 16'h0, ok);
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge CLK);
         if (rsp_valid === 1'b1) ok = 1'b1;
         n++;
      end
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++; $display("FAIL stall_first_valid: seen=%b want 1", ok);
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if ({rsp_valid, rsp_data, rsp_addr, rsp_last, RdEn} !==
             {1'b1, 16'h1234, 3'd2, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: valid=%b data=%h addr=%0d last=%b rden=%b want 1 1234 2 0 0",
                     i, rsp_valid, rsp_data, rsp_addr, rsp_last, RdEn);
         end
         @(negedge CLK);
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1 rsp_ready = 1'b0;
      get_beat(ok, d, a, l);
      vectors++;
      if ({ok, d, a, l} !== {1'b1, 16'h5678, 3'd3, 1'b1}) begin
         miscompares++;
         $display("FAIL stall_second: ok=%b data=%h addr=%0d last=%b want 1 5678 3 1", ok, d, a, l);
      end
   endtask

   task automatic test_back_to_back();
      logic ok, l;
      logic [15:0] d;
      logic [2:0] a;
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge CLK);
         if (cmd_ready === 1'b1) ok = 1'b1;
         n++;
      end
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 3'd4;
      for (int k = 0; k < 10; k++) begin
         cmd_data = 16'h0B00 + 16'(k);
         vectors++;
         if ({WrEn, cmd_ready, WrEn & RdEn} !== {(k % 2 == 1), (k % 2 == 0), 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_cycle[%0d]: wren=%b ready=%b both=%b want %b %b 0",
                     k, WrEn, cmd_ready, WrEn & RdEn, (k % 2 == 1), (k % 2 == 0));
         end
         if (k % 2 == 1) begin
            vectors++;
            if (WrData !== 16'h0B00 + 16'(k - 1)) begin
               miscompares++;
               $display("FAIL b2b_wrdata[%0d]: got %h want %h", k, WrData, 16'h0B00 + 16'(k - 1));
            end
         end
         @(negedge CLK);
      end
      cmd_valid = 1'b0;
      send_cmd(1'b1, 3'd4, 3'd0, 16'h0, ok);
      get_beat(ok, d, a, l);
      vectors++;
      if ({ok, d} !== {1'b1, 16'h0B08}) begin
         miscompares++; $display("FAIL b2b_readback: ok=%b data=%h want 1 0b08", ok, d);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic ok, l;
      logic [15:0] d;
      logic [2:0] a;
      int n = 0;
      send_cmd(1'b0, 3'd7, 3'd0, 16'h7777, ok);
      send_cmd(1'b1, 3'd0, 3'd7, 16'h0, ok);
      get_beat(ok, d, a, l);
      vectors++;
      if ({ok, d, a, l} !== {1'b1, 16'h0A00, 3'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL abort_beat0: ok=%b data=%h addr=%0d last=%b want 1 0a00 0 0", ok, d, a, l);
      end
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge CLK);
         if (RdEn === 1'b1) ok = 1'b1;
         n++;
      end
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++; $display("FAIL abort_beat1_rd: seen=%b want 1", ok);
      end
      RST = 1'b1;
      #1;
      vectors++;
      if ({rsp_valid, RdEn, WrEn, Address} !== 6'd0) begin
         miscompares++;
         $display("FAIL abort_async: valid=%b rden=%b wren=%b addr=%0d want 0 0 0 0",
                  rsp_valid, RdEn, WrEn, Address);
      end
      @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      vectors++;
      if ({cmd_ready, rsp_valid, RdEn} !== 3'b100) begin
         miscompares++;
         $display("FAIL abort_release: ready=%b valid=%b rden=%b want 1 0 0",
                  cmd_ready, rsp_valid, RdEn);
      end
      send_cmd(1'b1, 3'd7, 3'd0, 16'h0, ok);
      get_beat(ok, d, a, l);
      vectors++;
      if ({ok, d, a, l} !== {1'b1, 16'h7777, 3'd7, 1'b1}) begin
         miscompares++;
         $display("FAIL abort_readback: ok=%b data=%h addr=%0d last=%b want 1 7777 7 1", ok, d, a, l);
      end
   endtask

   task automatic test_timing();
      logic ok;
      int n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge CLK);
         if (cmd_ready === 1'b1) ok = 1'b1;
         n++;
      end
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 3'd5; cmd_len = 3'd0;
      @(posedge CLK);
      #1 cmd_valid = 1'b0;
      rsp_ready = 1'b1;  // held high from accept; must not cut RD/CAP short
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         vectors++;
         if ({RdEn, rsp_valid} !== {(c == 1), (c == 3)}) begin
            miscompares++;
            $display("FAIL timing_cycle[%0d]: rden=%b valid=%b want %b %b",
                     c, RdEn, rsp_valid, (c == 1), (c == 3));
         end
         if (c == 3) begin
            vectors++;
            if ({rsp_data, rsp_last} !== {16'h000A, 1'b1}) begin
               miscompares++;
               $display("FAIL timing_data: data=%h last=%b want 000a 1", rsp_data, rsp_last);
            end
         end
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_burst_wrap();
      test_stall();
      test_back_to_back();
      test_reset_mid_burst();
      test_timing();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
